// File: rtl/eco32_core_lsu_dcm_rid_alloc_pkg.sv
// Shared constants and helpers for the data-cache-miss RID allocator.
// Sizes: RID width 4, 16 RIDs per thread, 2 hardware threads.
package eco32_core_lsu_dcm_rid_alloc_pkg;

  localparam int RID_W = 4;
  localparam int RID_N = 16;
  localparam int THR_N = 2;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] RID_CNT = 5'd16;

  // Lowest-index set bit of a free mask; returns 0 for an empty mask.
  function automatic logic [RID_W-1:0] lowest_free(input logic [RID_N-1:0] m);
    logic [RID_W-1:0] idx;
    idx = {RID_W{1'b0}};
    for (int i = RID_N - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = i[RID_W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/eco32_core_lsu_dcm_rid_alloc_if.sv
// Request/push/release bundle between the miss issuer and the RID allocator.
interface eco32_core_lsu_dcm_rid_alloc_if;
  import eco32_core_lsu_dcm_rid_alloc_pkg::*;

  logic             req_stb;
  logic             req_tid;
  logic [1:0]       req_taf;
  logic             wr_stb;
  logic             wr_tid;
  logic [RID_W-1:0] wr_rid;
  logic             rel_stb;
  logic             rel_tid;
  logic [RID_W-1:0] rel_rid;
  logic [CNT_W-1:0] busy0;
  logic [CNT_W-1:0] busy1;
  logic             err;

  modport master (
    output req_stb, req_tid, rel_stb, rel_tid, rel_rid,
    input  req_taf, wr_stb, wr_tid, wr_rid, busy0, busy1, err
  );

  modport slave (
    input  req_stb, req_tid, rel_stb, rel_tid, rel_rid,
    output req_taf, wr_stb, wr_tid, wr_rid, busy0, busy1, err
  );

endinterface

// File: rtl/eco32_core_lsu_dcm_rid_alloc_pool.sv
// One thread's RID pool: free mask, lowest-free pick, busy counter,
// almost-empty flag and protocol-violation detect.
module eco32_core_lsu_dcm_rid_alloc_pool
  import eco32_core_lsu_dcm_rid_alloc_pkg::*;
#(
  parameter int AF_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_i,
  input  logic             rel_i,
  input  logic [RID_W-1:0] rel_rid_i,
  output logic             grant_o,
  output logic [RID_W-1:0] grant_rid_o,
  output logic [CNT_W-1:0] busy_o,
  output logic             taf_o,
  output logic             viol_o
);

  localparam logic [CNT_W-1:0] AF_CMP = CNT_W'(AF_LEVEL);

  logic [RID_N-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] busy_q, busy_d;
  logic             taf_q, taf_d;
  logic             empty_s, rel_ok_s;
  logic [CNT_W-1:0] free_d;

  assign empty_s     = (mask_q == {RID_N{1'b0}});
  assign grant_o     = alloc_i & ~empty_s;
  assign grant_rid_o = lowest_free(mask_q);
  assign rel_ok_s    = rel_i & ~mask_q[rel_rid_i];
  assign viol_o      = (alloc_i & empty_s) | (rel_i & mask_q[rel_rid_i]);

  // The grant picks a set bit and a legal release targets a clear bit, so
  // the two never collide and the released RID is invisible to this cycle's pick.
  always_comb begin
    mask_d = mask_q;
    busy_d = busy_q;
    if (grant_o) begin
      mask_d[grant_rid_o] = 1'b0;
    end else begin
      mask_d = mask_d;
    end
    if (rel_ok_s) begin
      mask_d[rel_rid_i] = 1'b1;
    end else begin
      mask_d = mask_d;
    end
    busy_d = busy_q + {{(CNT_W-1){1'b0}}, grant_o} - {{(CNT_W-1){1'b0}}, rel_ok_s};
    free_d = RID_CNT - busy_d;
    taf_d  = (free_d <= AF_CMP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= {RID_N{1'b1}};
      busy_q <= {CNT_W{1'b0}};
      taf_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      busy_q <= busy_d;
      taf_q  <= taf_d;
    end
  end

  assign busy_o = busy_q;
  assign taf_o  = taf_q;

endmodule

// File: rtl/eco32_core_lsu_dcm_rid_alloc.sv
// Per-thread data-cache-miss RID allocator: tid demux into two pools,
// registered RID push toward the RID FIFO and a sticky violation flag.
module eco32_core_lsu_dcm_rid_alloc
  import eco32_core_lsu_dcm_rid_alloc_pkg::*;
#(
  parameter int AF_LEVEL = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  eco32_core_lsu_dcm_rid_alloc_if.slave      bus
);

  logic             alloc0_s, alloc1_s, rel0_s, rel1_s;
  logic             grant0_s, grant1_s, viol0_s, viol1_s, taf0_s, taf1_s;
  logic [RID_W-1:0] rid0_s, rid1_s;
  logic [CNT_W-1:0] busy0_s, busy1_s;

  logic             wr_stb_q, wr_stb_d;
  logic             wr_tid_q, wr_tid_d;
  logic [RID_W-1:0] wr_rid_q, wr_rid_d;
  logic             err_q, err_d;

  assign alloc0_s = bus.req_stb & (bus.req_tid == 1'b0);
  assign alloc1_s = bus.req_stb & (bus.req_tid == 1'b1);
  assign rel0_s   = bus.rel_stb & (bus.rel_tid == 1'b0);
  assign rel1_s   = bus.rel_stb & (bus.rel_tid == 1'b1);

  eco32_core_lsu_dcm_rid_alloc_pool #(.AF_LEVEL(AF_LEVEL)) u_pool0 (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc0_s),
    .rel_i       (rel0_s),
    .rel_rid_i   (bus.rel_rid),
    .grant_o     (grant0_s),
    .grant_rid_o (rid0_s),
    .busy_o      (busy0_s),
    .taf_o       (taf0_s),
    .viol_o      (viol0_s)
  );

  eco32_core_lsu_dcm_rid_alloc_pool #(.AF_LEVEL(AF_LEVEL)) u_pool1 (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc1_s),
    .rel_i       (rel1_s),
    .rel_rid_i   (bus.rel_rid),
    .grant_o     (grant1_s),
    .grant_rid_o (rid1_s),
    .busy_o      (busy1_s),
    .taf_o       (taf1_s),
    .viol_o      (viol1_s)
  );

  // Push mux: tid/rid hold their last value while no push is pending.
  always_comb begin
    wr_stb_d = grant0_s | grant1_s;
    wr_tid_d = wr_tid_q;
    wr_rid_d = wr_rid_q;
    if (grant1_s) begin
      wr_tid_d = 1'b1;
      wr_rid_d = rid1_s;
    end else if (grant0_s) begin
      wr_tid_d = 1'b0;
      wr_rid_d = rid0_s;
    end else begin
      wr_tid_d = wr_tid_q;
    end
    err_d = err_q | viol0_s | viol1_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stb_q <= 1'b0;
      wr_tid_q <= 1'b0;
      wr_rid_q <= {RID_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      wr_stb_q <= wr_stb_d;
      wr_tid_q <= wr_tid_d;
      wr_rid_q <= wr_rid_d;
      err_q    <= err_d;
    end
  end

  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_tid  = wr_tid_q;
  assign bus.wr_rid  = wr_rid_q;
  assign bus.err     = err_q;
  assign bus.busy0   = busy0_s;
  assign bus.busy1   = busy1_s;
  assign bus.req_taf = {taf1_s, taf0_s};

endmodule

// File: tb/tb_eco32_core_lsu_dcm_rid_alloc.sv
// Directed self-checking bench for the DCM RID allocator; inputs change 1ns
// after a rising edge and outputs are sampled at that same point.
module tb_eco32_core_lsu_dcm_rid_alloc;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  eco32_core_lsu_dcm_rid_alloc_if bus ();

  eco32_core_lsu_dcm_rid_alloc #(.AF_LEVEL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_stb = 1'b0;
    bus.req_tid = 1'b0;
    bus.rel_stb = 1'b0;
    bus.rel_tid = 1'b0;
    bus.rel_rid = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic release_rid(input logic tid, input logic [3:0] rid);
    bus.rel_stb = 1'b1;
    bus.rel_tid = tid;
    bus.rel_rid = rid;
    step();
    bus.rel_stb = 1'b0;
  endtask

  task automatic alloc(input logic tid);
    bus.req_stb = 1'b1;
    bus.req_tid = tid;
    step();
    bus.req_stb = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // 1. reset / idle state
    chk("rst_busy0", int'(bus.busy0), 0);
    chk("rst_busy1", int'(bus.busy1), 0);
    chk("rst_taf", int'(bus.req_taf), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_wr_stb", int'(bus.wr_stb), 0);

    // 2. 16 back-to-back allocations on tid 0
    bus.req_stb = 1'b1;
    bus.req_tid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("burst_stb%0d", i), int'(bus.wr_stb), 1);
      chk($sformatf("burst_rid%0d", i), int'(bus.wr_rid), i);
      chk($sformatf("burst_tid%0d", i), int'(bus.wr_tid), 0);
      chk($sformatf("burst_taf0_%0d", i), int'(bus.req_taf[0]), (i >= 13) ? 1 : 0);
    end
    bus.req_stb = 1'b0;
    chk("full_busy0", int'(bus.busy0), 16);

    // 4. release/realloc from full, then double free
    release_rid(1'b0, 4'd5);
    chk("rel5_busy0", int'(bus.busy0), 15);
    chk("rel5_err", int'(bus.err), 0);
    chk("rel5_taf0", int'(bus.req_taf[0]), 1);
    alloc(1'b0);
    chk("realloc_stb", int'(bus.wr_stb), 1);
    chk("realloc_rid", int'(bus.wr_rid), 5);
    chk("realloc_busy0", int'(bus.busy0), 16);
    release_rid(1'b0, 4'd5);
    chk("rel5b_busy0", int'(bus.busy0), 15);
    chk("rel5b_err", int'(bus.err), 0);
    release_rid(1'b0, 4'd5);
    chk("dfree_busy0", int'(bus.busy0), 15);
    chk("dfree_err", int'(bus.err), 1);
    chk("dfree_wr_stb", int'(bus.wr_stb), 0);

    // 3. pool exhaustion on tid 0 from a clean state
    do_reset();
    step();
    chk("rst2_err", int'(bus.err), 0);
    bus.req_stb = 1'b1;
    bus.req_tid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("refill_busy0", int'(bus.busy0), 16);
    chk("refill_err", int'(bus.err), 0);
    step();
    bus.req_stb = 1'b0;
    chk("empty_wr_stb", int'(bus.wr_stb), 0);
    chk("empty_err", int'(bus.err), 1);
    chk("empty_busy0", int'(bus.busy0), 16);
    chk("empty_taf1", int'(bus.req_taf[1]), 0);
    chk("empty_busy1", int'(bus.busy1), 0);

    // 5. same-cycle alloc + release on tid 0 with only rid 0 busy
    do_reset();
    alloc(1'b0);
    chk("pre_rid", int'(bus.wr_rid), 0);
    chk("pre_busy0", int'(bus.busy0), 1);
    bus.req_stb = 1'b1;
    bus.req_tid = 1'b0;
    bus.rel_stb = 1'b1;
    bus.rel_tid = 1'b0;
    bus.rel_rid = 4'd0;
    step();
    idle_inputs();
    chk("same_stb", int'(bus.wr_stb), 1);
    chk("same_rid", int'(bus.wr_rid), 1);
    chk("same_busy0", int'(bus.busy0), 1);
    chk("same_err", int'(bus.err), 0);
    alloc(1'b0);
    chk("after_same_rid", int'(bus.wr_rid), 0);
    chk("after_same_busy0", int'(bus.busy0), 2);
    alloc(1'b1);
    chk("t1_stb", int'(bus.wr_stb), 1);
    chk("t1_tid", int'(bus.wr_tid), 1);
    chk("t1_rid", int'(bus.wr_rid), 0);
    chk("t1_busy1", int'(bus.busy1), 1);
    chk("t1_busy0", int'(bus.busy0), 2);

    // 6. reset pulse in the middle of an allocation burst
    release_rid(1'b1, 4'd15);
    chk("t1_dfree_err", int'(bus.err), 1);
    bus.req_stb = 1'b1;
    bus.req_tid = 1'b0;
    step();
    step();
    chk("midburst_stb", int'(bus.wr_stb), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_wr_stb", int'(bus.wr_stb), 0);
    chk("midrst_busy0", int'(bus.busy0), 0);
    chk("midrst_busy1", int'(bus.busy1), 0);
    chk("midrst_err", int'(bus.err), 0);
    chk("midrst_taf", int'(bus.req_taf), 0);
    step();
    bus.req_stb = 1'b0;
    chk("postrst_stb", int'(bus.wr_stb), 1);
    chk("postrst_rid", int'(bus.wr_rid), 0);
    chk("postrst_busy0", int'(bus.busy0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
